// File: rtl/lsu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl_pkg
// Brief    : funct3 codes, response error codes and FSM states for lsu_ctrl
// Revision : 1.0 - initial release
// ============================================================================
package lsu_ctrl_pkg;

  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_D  = 3'b011;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;
  localparam logic [2:0] c_F3_WU = 3'b110;
  localparam logic [2:0] c_F3_RSV = 3'b111;

  localparam logic [1:0] c_ERR_OK       = 2'b00;
  localparam logic [1:0] c_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] c_ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] c_ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSREQ  = 2'd1,
    S_BUSWAIT = 2'd2,
    S_RESP    = 2'd3
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : combinational byte-lane steering, load extension and legality flags
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN/8
) (
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [2:0]        i_addr_lo,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [STRB_W-1:0] o_wstrb,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_misalign,
  output logic              o_illegal
);

  localparam int c_OFF_W = $clog2(STRB_W);

  logic [c_OFF_W-1:0] w_off;
  logic [c_OFF_W+2:0] w_bit_off;
  logic [XLEN-1:0]    w_ones;
  logic [XLEN-1:0]    w_shifted;
  logic [XLEN-1:0]    w_keep;
  logic [STRB_W-1:0]  w_mask;
  logic               w_sign;

  assign w_off     = i_addr_lo[c_OFF_W-1:0];
  assign w_bit_off = {w_off, 3'b000};
  assign w_ones    = '1;
  assign w_shifted = i_rdata >> w_bit_off;

  always_comb begin
    w_mask     = '1;
    w_keep     = w_ones;
    w_sign     = 1'b0;
    o_misalign = 1'b0;
    case (i_funct3[1:0])
      2'b00: begin
        w_mask = STRB_W'(1);
        w_keep = w_ones >> (XLEN-8);
        w_sign = w_shifted[7];
      end
      2'b01: begin
        w_mask     = STRB_W'(3);
        w_keep     = w_ones >> (XLEN-16);
        w_sign     = w_shifted[15];
        o_misalign = i_addr_lo[0];
      end
      2'b10: begin
        w_mask     = STRB_W'(15);
        w_keep     = w_ones >> (XLEN-32);
        w_sign     = w_shifted[31];
        o_misalign = |i_addr_lo[1:0];
      end
      default: begin
        o_misalign = |i_addr_lo[2:0];
      end
    endcase
    // Unsigned loads never fill the upper bits with ones
    if (i_funct3[2]) w_sign = 1'b0;
  end

  assign o_rdata   = (w_shifted & w_keep) | (w_sign ? ~w_keep : '0);
  assign o_wstrb   = i_we ? (w_mask << w_off) : '0;
  assign o_wdata   = i_wdata << w_bit_off;
  assign o_illegal = (i_funct3 == c_F3_RSV) || (i_we && i_funct3[2]) ||
                     ((XLEN == 32) && ((i_funct3 == c_F3_D) || (i_funct3 == c_F3_WU)));

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Brief    : valid/ready load/store unit; define LSU_TIMEOUT_EN for the bus watchdog
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int STRB_W         = XLEN/8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int c_OFF_W = $clog2(STRB_W);

  lsu_state_e        r_state;
  lsu_state_e        w_state_next;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [2:0]        r_addr_lo;
  logic              r_mem_we;
  logic [XLEN-1:0]   r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;
  logic [STRB_W-1:0] r_mem_wstrb;
  logic [XLEN-1:0]   r_rsp_rdata;
  logic [1:0]        r_rsp_err;

  logic              w_idle;
  logic              w_accept;
  logic              w_bus_done;
  logic              w_progress;
  logic              w_busy;
  logic              w_timeout;
  logic              w_a_we;
  logic [2:0]        w_a_funct3;
  logic [2:0]        w_a_addr_lo;
  logic [STRB_W-1:0] w_wstrb;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_rdata_ext;
  logic              w_misalign;
  logic              w_illegal;

  // One aligner serves both the incoming request and the latched one
  assign w_idle      = (r_state == S_IDLE);
  assign w_a_we      = w_idle ? req_we : r_we;
  assign w_a_funct3  = w_idle ? req_funct3 : r_funct3;
  assign w_a_addr_lo = w_idle ? req_addr[2:0] : r_addr_lo;

  lsu_align #(
    .XLEN   (XLEN),
    .STRB_W (STRB_W)
  ) u_align (
    .i_we       (w_a_we),
    .i_funct3   (w_a_funct3),
    .i_addr_lo  (w_a_addr_lo),
    .i_wdata    (req_wdata),
    .i_rdata    (mem_rdata),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata_ext),
    .o_misalign (w_misalign),
    .o_illegal  (w_illegal)
  );

  assign w_accept   = w_idle && req_valid;
  assign w_bus_done = ((r_state == S_BUSREQ) && mem_req_ready && mem_rsp_valid) ||
                      ((r_state == S_BUSWAIT) && mem_rsp_valid);
  assign w_progress = ((r_state == S_BUSREQ) && mem_req_ready) || w_bus_done;
  assign w_busy     = (r_state == S_BUSREQ) || (r_state == S_BUSWAIT);

`ifdef LSU_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES+1);
  logic [c_TMO_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_tmo_cnt <= '0;
    end else if (w_busy) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_timeout = w_busy && !w_progress && (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES-1));
`else
  // No watchdog in this build; the comparison is constant false
  assign w_timeout = w_busy && (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_state_next = (w_illegal || w_misalign) ? S_RESP : S_BUSREQ;
      end
      S_BUSREQ: begin
        if (mem_req_ready) w_state_next = mem_rsp_valid ? S_RESP : S_BUSWAIT;
        else if (w_timeout) w_state_next = S_RESP;
      end
      S_BUSWAIT: begin
        if (mem_rsp_valid || w_timeout) w_state_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    mem_req_valid = 1'b0;
    case (r_state)
      S_IDLE:   req_ready     = 1'b1;
      S_BUSREQ: mem_req_valid = 1'b1;
      S_RESP:   rsp_valid     = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= c_ERR_OK;
    end else if (w_accept) begin
      r_we        <= req_we;
      r_funct3    <= req_funct3;
      r_addr_lo   <= req_addr[2:0];
      r_rsp_rdata <= '0;
      r_rsp_err   <= w_illegal  ? c_ERR_ILLEGAL :
                     w_misalign ? c_ERR_MISALIGN : c_ERR_OK;
      if (!(w_illegal || w_misalign)) begin
        r_mem_we    <= req_we;
        r_mem_addr  <= {req_addr[XLEN-1:c_OFF_W], {c_OFF_W{1'b0}}};
        r_mem_wdata <= w_wdata;
        r_mem_wstrb <= w_wstrb;
      end
    end else if (w_bus_done) begin
      r_rsp_rdata <= r_we ? '0 : w_rdata_ext;
      r_rsp_err   <= c_ERR_OK;
    end else if (w_timeout) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= c_ERR_TIMEOUT;
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Brief    : directed and random transactions against a byte-level model of the LSU
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

`ifdef LSU_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 256;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;

  logic        q_req_valid, q_req_ready, q_req_we;
  logic [2:0]  q_funct3;
  logic [31:0] q_addr, q_wdata;
  logic        q_rsp_valid, q_rsp_ready;
  logic [31:0] q_rsp_rdata;
  logic [1:0]  q_rsp_err;
  logic        q_mem_req_valid, q_mem_req_ready, q_mem_we;
  logic [31:0] q_mem_addr, q_mem_wdata;
  logic [3:0]  q_mem_wstrb;
  logic        q_mem_rsp_valid;
  logic [31:0] q_mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.XLEN(64), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  // 32-bit instance with a zero-wait bus that answers in the request cycle
  assign q_mem_rsp_valid = q_mem_req_valid;

  lsu_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(q_req_valid), .req_ready(q_req_ready), .req_we(q_req_we),
    .req_funct3(q_funct3), .req_addr(q_addr), .req_wdata(q_wdata),
    .rsp_valid(q_rsp_valid), .rsp_ready(q_rsp_ready), .rsp_rdata(q_rsp_rdata), .rsp_err(q_rsp_err),
    .mem_req_valid(q_mem_req_valid), .mem_req_ready(q_mem_req_ready), .mem_we(q_mem_we),
    .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata), .mem_wstrb(q_mem_wstrb),
    .mem_rsp_valid(q_mem_rsp_valid), .mem_rdata(q_mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [1:0] m_err(input logic we, input logic [2:0] f3,
                                       input logic [63:0] addr, input int xlen);
    if (f3 == 3'd7 || (we && f3[2]) || (xlen == 32 && (f3 == 3'd3 || f3 == 3'd6)))
      return 2'b10;
    if ((addr % nbytes(f3)) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] addr,
                                         input logic [63:0] data, input int xlen);
    int off;
    int n;
    logic [63:0] r;
    off = int'(addr % (xlen / 8));
    n   = nbytes(f3);
    r   = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = data[8*(off+i) +: 8];
    if (!f3[2] && r[8*n-1]) for (int i = 8*n; i < 64; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] m_strb(input logic we, input logic [2:0] f3, input logic [63:0] addr);
    logic [7:0] s;
    int off;
    s   = '0;
    off = int'(addr % 8);
    if (we) for (int i = 0; i < nbytes(f3); i++) s[off+i] = 1'b1;
    return s;
  endfunction

  task automatic txn(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [63:0] rdata,
                     input int req_lat, input int rsp_lat, input int rrdy_lat, input string tag);
    logic [1:0]  e_err;
    logic [63:0] e_rdata;
    e_err   = m_err(we, f3, addr, 64);
    e_rdata = (e_err == 2'b00 && !we) ? m_load(f3, addr, rdata, 64) : 64'd0;
    chk({tag, ".req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    if (e_err != 2'b00) begin
      chk({tag, ".no_bus"}, mem_req_valid, 0);
    end else begin
      for (int c = 0; c <= req_lat; c++) begin
        chk({tag, ".mem_req_valid"}, mem_req_valid, 1);
        chk({tag, ".mem_addr"}, mem_addr, addr & ~64'h7);
        chk({tag, ".mem_we"}, mem_we, we);
        chk({tag, ".mem_wstrb"}, mem_wstrb, m_strb(we, f3, addr));
        if (we) chk({tag, ".mem_wdata"}, mem_wdata, wdata << (8 * (addr % 8)));
        chk({tag, ".req_ready_busy"}, req_ready, 0);
        if (c == req_lat) begin
          mem_req_ready = 1'b1;
          if (rsp_lat == 0) begin mem_rsp_valid = 1'b1; mem_rdata = rdata; end
        end
        step();
      end
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = {$urandom, $urandom};
      for (int c = 1; c <= rsp_lat; c++) begin
        chk({tag, ".wait_no_req"}, mem_req_valid, 0);
        chk({tag, ".wait_no_rsp"}, rsp_valid, 0);
        if (c == rsp_lat) begin mem_rsp_valid = 1'b1; mem_rdata = rdata; end
        step();
      end
      mem_rsp_valid = 1'b0; mem_rdata = {$urandom, $urandom};
    end
    for (int c = 0; c <= rrdy_lat; c++) begin
      chk({tag, ".rsp_valid"}, rsp_valid, 1);
      chk({tag, ".rsp_err"}, rsp_err, e_err);
      chk({tag, ".rsp_rdata"}, rsp_rdata, e_rdata);
      chk({tag, ".req_ready_resp"}, req_ready, 0);
      if (c == rrdy_lat) rsp_ready = 1'b1;
      step();
    end
    rsp_ready = 1'b0;
    chk({tag, ".rsp_done"}, rsp_valid, 0);
    chk({tag, ".req_ready_after"}, req_ready, 1);
  endtask

  task automatic txn32(input logic [2:0] f3, input logic [31:0] addr, input string tag);
    logic [1:0]  e_err;
    logic [63:0] e_full;
    e_err = m_err(1'b0, f3, {32'd0, addr}, 32);
    q_mem_rdata = $urandom;
    e_full = (e_err == 2'b00) ? m_load(f3, {32'd0, addr}, {32'd0, q_mem_rdata}, 32) : 64'd0;
    q_req_valid = 1'b1; q_funct3 = f3; q_addr = addr;
    step();
    q_req_valid = 1'b0;
    if (e_err == 2'b00) begin
      chk({tag, ".mem_req_valid"}, q_mem_req_valid, 1);
      step();
    end else begin
      chk({tag, ".no_bus"}, q_mem_req_valid, 0);
    end
    chk({tag, ".rsp_valid"}, q_rsp_valid, 1);
    chk({tag, ".rsp_err"}, q_rsp_err, e_err);
    chk({tag, ".rsp_rdata"}, q_rsp_rdata, e_full[31:0]);
    step();
    chk({tag, ".req_ready"}, q_req_ready, 1);
  endtask

  initial begin
    logic        r_we;
    logic [2:0]  r_f3;
    logic [63:0] r_addr;
    int          n;

    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    q_req_valid = 1'b0; q_req_we = 1'b0; q_funct3 = '0; q_addr = '0; q_wdata = '0;
    q_rsp_ready = 1'b1; q_mem_req_ready = 1'b1; q_mem_rdata = '0;
    step();
    step();
    chk("rst.req_ready", req_ready, 1);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.mem_req_valid", mem_req_valid, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.rsp_err", rsp_err, 0);
    rst = 1'b1;
    step();

    txn(1'b0, 3'b000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 0, "lb_sign");
    txn(1'b1, 3'b001, 64'h8000_0006, 64'hBEEF, 64'd0, 1, 2, 0, "sh_lane");
    txn(1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 0, 0, 0, "lw_misalign");
    txn(1'b1, 3'b100, 64'h8000_0000, 64'h12, 64'd0, 0, 0, 0, "sbu_illegal");
    txn(1'b1, 3'b011, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'd0, 5, 1, 3, "sd_backpressure");
    txn(1'b0, 3'b101, 64'h8000_0006, 64'd0, 64'hFFEE_DDCC_BBAA_9988, 2, 3, 1, "lhu_hi");
    txn(1'b0, 3'b110, 64'h8000_0004, 64'd0, 64'h8765_4321_0000_0000, 0, 1, 0, "lwu_hi");
    txn(1'b0, 3'b111, 64'h8000_0000, 64'd0, 64'd0, 0, 0, 1, "f3_reserved");

    // Abort a store sitting in BUSWAIT, then offer a stray response
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b011;
    req_addr = 64'h0000_1000; req_wdata = 64'hCAFE_F00D_DEAD_BEEF;
    step();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("abort.in_wait", mem_req_valid, 0);
    chk("abort.pre_wstrb", mem_wstrb, 8'hFF);
    #1 rst = 1'b0;
    #1;
    chk("abort.req_ready", req_ready, 1);
    chk("abort.rsp_valid", rsp_valid, 0);
    chk("abort.mem_req_valid", mem_req_valid, 0);
    chk("abort.mem_we", mem_we, 0);
    chk("abort.mem_addr", mem_addr, 0);
    chk("abort.mem_wdata", mem_wdata, 0);
    chk("abort.mem_wstrb", mem_wstrb, 0);
    chk("abort.rsp_rdata", rsp_rdata, 0);
    chk("abort.rsp_err", rsp_err, 0);
    step();
    rst = 1'b1;
    step();
    mem_rsp_valid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    step();
    mem_rsp_valid = 1'b0;
    chk("stray.rsp_valid", rsp_valid, 0);
    chk("stray.req_ready", req_ready, 1);
    step();
    chk("stray.rsp_valid_later", rsp_valid, 0);

    for (int i = 0; i < 60; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~64'(nbytes(r_f3) - 1);
      txn(r_we, r_f3, r_addr, {$urandom, $urandom}, {$urandom, $urandom},
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), "rand");
    end

    txn32(3'b011, 32'h0000_0100, "x32_ld");
    txn32(3'b110, 32'h0000_0104, "x32_lwu");
    txn32(3'b001, 32'h0000_0102, "x32_lh");
    txn32(3'b100, 32'h0000_0103, "x32_lbu");

`ifdef LSU_TIMEOUT_EN
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 64'h100;
    step();
    req_valid = 1'b0;
    n = 0;
    while (mem_req_valid && n < TMO + 4) begin
      n++;
      step();
    end
    chk("tmo.cycles", 64'(n), 64'(TMO));
    chk("tmo.rsp_valid", rsp_valid, 1);
    chk("tmo.rsp_err", rsp_err, 2'b11);
    chk("tmo.rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("tmo.req_ready", req_ready, 1);
`else
    n = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Parametrised load/store unit that replaces the direct, single-cycle mem_r/mem_w/mem_dlen plus bidirectional data bus path with a multi-cycle valid/ready memory interface.
- Sits between the EXU, which issues one load/store per request, and the memory/bus port.
- Handles byte-lane alignment, write strobes, load sign/zero extension, misalignment detection and response back-pressure.

Parameters:
- XLEN, 64, data and address width; 32 or 64 only.
- STRB_W, XLEN/8, write-strobe width; derived, not overridden.
- TIMEOUT_CYCLES, 256, bus wait limit; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  EXU request valid
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV size/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, LSB-aligned
- rsp_valid  out  1  response valid
- rsp_ready  in  1  EXU accepts response
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
- rsp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_we  out  1  bus write
- mem_addr  out  XLEN  req_addr with low log2(STRB_W) bits cleared
- mem_wdata  out  XLEN  store data shifted to its byte lane
- mem_wstrb  out  STRB_W  byte enables; all 0 for reads
- mem_rsp_valid  in  1  bus read data / write ack valid
- mem_rdata  in  XLEN  aligned bus read data

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. req_ready=1. rsp_valid, mem_req_valid, mem_we=0. mem_addr, mem_wdata, mem_wstrb, rsp_rdata, rsp_err=0. All internal latches cleared.
- FSM states: IDLE, BUSREQ, BUSWAIT, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch the request.
  - Legality check: funct3=111 is illegal, store with funct3[2]=1 is illegal, and funct3 011/110 are illegal when XLEN=32. Any of these gives err=10 and goes to RESP.
  - Alignment check: address not aligned to access size (H: addr[0], W: addr[1:0], D: addr[2:0]) gives err=01 and goes to RESP. No bus activity for either error.
  - Otherwise go to BUSREQ. mem_* outputs are registered, so mem_req_valid rises the cycle after acceptance.
- BUSREQ:
  - mem_req_valid=1. mem_* held stable until mem_req_ready.
  - On handshake go to BUSWAIT.
  - If mem_rsp_valid is also high in the handshake cycle, capture the data and go directly to RESP.
- BUSWAIT: on mem_rsp_valid, capture mem_rdata and go to RESP. mem_rsp_valid outside BUSREQ/BUSWAIT is ignored.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err held until rsp_ready. On handshake go to IDLE.
  - req_ready=0 in every state except IDLE. The next request is accepted at the earliest the cycle after the response handshake.
- Store lane rules, with off = addr[log2(STRB_W)-1:0]:
  - mem_wstrb = size mask (1, 3, F, FF) << off.
  - mem_wdata = req_wdata << (8*off).
- Load extraction: data = mem_rdata >> (8*off), truncated to the access size, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1) to XLEN.
- Minimum latency for a load with a zero-wait bus: accept at cycle 0, mem_req_valid at cycle 1, rsp_valid at cycle 2.
- Reset mid-transaction aborts immediately to IDLE. A late mem_rsp_valid after reset is ignored.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - A counter runs in BUSREQ and BUSWAIT and is cleared on every state entry.
  - When it reaches TIMEOUT_CYCLES without progress, mem_req_valid drops and the FSM goes to RESP with err=11 and rdata=0.
- Not defined: no counter; the LSU waits indefinitely.

Decomposition:
- Shared package holds:
  - the funct3 size/sign constants;
  - the rsp_err encodings;
  - the FSM state enum.
- One sub-module, lsu_align: purely combinational, computing wstrb, wdata shift, load extract/extend and the misalign/illegal flags. lsu_ctrl holds the FSM, registers and timeout counter.

Test Plan:
- LD funct3=000, addr=0x80000003, mem_rdata=0x00000000_80000000 (byte 3 = 0x80) -> mem_addr=0x80000000, rsp_rdata=0xFFFFFFFFFFFFFF80, err=00, rsp_valid 2 cycles after accept with zero-wait bus.
- SH funct3=001, addr=0x80000006, wdata=0xBEEF -> mem_wstrb=0xC0, mem_wdata=0xBEEF000000000000, mem_we=1; ack -> rsp_valid, rdata=0.
- LW funct3=010 at addr=0x80000002 -> no mem_req_valid, rsp_err=01 the cycle after accept. SB funct3=100 -> rsp_err=10.
- Back-pressure: mem_req_ready low for 5 cycles, then rsp_ready low for 3 cycles -> mem_* stable throughout, rsp_* stable, req_ready=0 until the rsp handshake.
- Assert rst=0 in BUSWAIT, then release and drive a stray mem_rsp_valid -> all outputs 0 asynchronously, stray response ignored, req_ready=1.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, bus never responds -> rsp_err=11 after 8 wait cycles. XLEN=32 build: LD funct3=011 -> err=10.
